fetch_align_buf: RTL and testbench

FETCH_ALIGN_BUF -- requirements
Module: fetch_align_buf

---
 rtl/fetch_align_buf_pkg.sv | 25 ++
 rtl/fetch_align_buf_istr_len_dec.sv | 21 ++
 rtl/fetch_align_buf.sv | 119 +++++++++++
 tb/tb_fetch_align_buf.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_align_buf_pkg.sv
// Shared fetch/decode definitions: instruction length encodings and the
// halfword-count helper used by the fetch alignment buffer.
package fetch_align_buf_pkg;

    typedef enum logic [1:0] {
        ISTR_LEN16 = 2'd0,
        ISTR_LEN32 = 2'd1,
        ISTR_LEN48 = 2'd2
    } istr_len_e;

    localparam int FETCH_HW = 4;

    function automatic logic [1:0] istrHalfwords(input istr_len_e len);
        logic [1:0] hw;
        hw = 2'd1;
        case (len)
            ISTR_LEN16: hw = 2'd1;
            ISTR_LEN32: hw = 2'd2;
            ISTR_LEN48: hw = 2'd3;
            default:    hw = 2'd1;
        endcase
        return hw;
    endfunction

endpackage

// File: rtl/fetch_align_buf_istr_len_dec.sv
// Combinational instruction-length decode from the first halfword of an
// instruction.
module istr_len_dec
    import fetch_align_buf_pkg::*;
(
    input  logic [15:0] halfword,
    output istr_len_e   len
);

    // Only the top six bits carry length information.
    logic unusedLowBits;
    assign unusedLowBits = ^halfword[9:0];

    always_comb begin
        len = ISTR_LEN16;
        if (halfword[15:12] == 4'hF) begin
            len = (halfword[11:10] == 2'b11) ? ISTR_LEN48 : ISTR_LEN32;
        end
    end

endmodule

// File: rtl/fetch_align_buf.sv
// Fetch alignment buffer: turns 8-byte fetch blocks into a stream of
// 16/32/48-bit instructions held in a shifting halfword queue.
module fetch_align_buf
    import fetch_align_buf_pkg::*;
#(
    parameter int PCW   = 32,
    parameter int BUFHW = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [63:0]    fetchData,
    input  logic           fetchValid,
    output logic           fetchReady,
    input  logic           redirect,
    input  logic [PCW-1:0] redirectPc,
    output logic [63:0]    istrWord,
    output logic [1:0]     istrLen,
    output logic [PCW-1:0] istrPc,
    output logic           istrValid,
    input  logic           istrTake
);

    logic [15:0]    hwReg   [BUFHW];
    logic [15:0]    hwNext  [BUFHW];
    logic [15:0]    fetchHw [FETCH_HW];
    logic [3:0]     countReg;
    logic [1:0]     skipReg;
    logic [PCW-1:0] pcReg;

    istr_len_e  headLen;
    logic [1:0] headHw;
    logic       take;
    logic       accept;
    logic [1:0] popHw;
    logic [2:0] appendHw;
    logic [3:0] remaining;
    logic       unusedPcBit;

    genvar gi;

    assign unusedPcBit = redirectPc[0];

    istr_len_dec uLenDec (
        .halfword (hwReg[0]),
        .len      (headLen)
    );

    assign headHw    = istrHalfwords(headLen);
    assign istrValid = (countReg != 4'd0) && (countReg >= {2'b00, headHw});
    assign istrLen   = headLen;
    assign istrPc    = pcReg;

    // Room check is written as count + 4 <= 8 + skip to avoid an underflowing subtract.
    assign fetchReady = (({1'b0, countReg} + 5'd4) <= (5'(BUFHW) + {3'b000, skipReg}))
                        && !redirect && !reset;

    assign take      = istrTake && istrValid;
    assign accept    = fetchValid && fetchReady;
    assign popHw     = take ? headHw : 2'd0;
    assign appendHw  = accept ? (3'd4 - {1'b0, skipReg}) : 3'd0;
    assign remaining = countReg - {2'b00, popHw};

    generate
        for (gi = 0; gi < FETCH_HW; gi++) begin : gFetchHw
            assign fetchHw[gi] = fetchData[16*gi +: 16];
        end

        for (gi = 0; gi < FETCH_HW; gi++) begin : gWord
            assign istrWord[16*gi +: 16] =
                ((3'(gi) < {1'b0, headHw}) && (4'(gi) < countReg)) ? hwReg[gi] : 16'h0000;
        end

        // Each slot takes either the surviving queue entry after the pop or,
        // inside the append window, the matching lane of the incoming block.
        for (gi = 0; gi < BUFHW; gi++) begin : gSlot
            logic [3:0]  slotPos;
            logic [3:0]  srcIdx;
            logic [15:0] keptHw;
            logic        inAppend;
            logic [1:0]  laneIdx;

            assign slotPos  = 4'(gi);
            assign srcIdx   = slotPos + {2'b00, popHw};
            assign keptHw   = (srcIdx < 4'(BUFHW)) ? hwReg[srcIdx[2:0]] : 16'h0000;
            assign inAppend = accept && (slotPos >= remaining)
                              && (slotPos < (remaining + {1'b0, appendHw}));
            assign laneIdx  = slotPos[1:0] - remaining[1:0] + skipReg;
            assign hwNext[gi] = inAppend ? fetchHw[laneIdx] : keptHw;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            countReg <= '0;
            skipReg  <= '0;
            pcReg    <= '0;
            for (int i = 0; i < BUFHW; i++) begin
                hwReg[i] <= '0;
            end
        end else if (redirect) begin
            // Stale halfwords stay in the array; a zero count masks them.
            countReg <= '0;
            skipReg  <= redirectPc[2:1];
            pcReg    <= {redirectPc[PCW-1:1], 1'b0};
        end else begin
            countReg <= remaining + {1'b0, appendHw};
            for (int i = 0; i < BUFHW; i++) begin
                hwReg[i] <= hwNext[i];
            end
            if (take) begin
                pcReg <= pcReg + PCW'({headHw, 1'b0});
            end
            if (accept) begin
                skipReg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_align_buf.sv
// Bench for fetch_align_buf: directed vector table, hand-written corner
// sequences and a random instruction stream against a queue-level model.
module tb_fetch_align_buf;

    localparam int PCW   = 32;
    localparam int MEMHW = 128;

    logic           clock = 1'b0;
    logic           reset;
    logic [63:0]    fetchData;
    logic           fetchValid;
    logic           fetchReady;
    logic           redirect;
    logic [PCW-1:0] redirectPc;
    logic [63:0]    istrWord;
    logic [1:0]     istrLen;
    logic [PCW-1:0] istrPc;
    logic           istrValid;
    logic           istrTake;

    always #5 clock = ~clock;

    fetch_align_buf #(.PCW(PCW), .BUFHW(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .fetchData  (fetchData),
        .fetchValid (fetchValid),
        .fetchReady (fetchReady),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .istrWord   (istrWord),
        .istrLen    (istrLen),
        .istrPc     (istrPc),
        .istrValid  (istrValid),
        .istrTake   (istrTake)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of halfwords plus PC and skip.
    logic [15:0]    mq[$];
    logic [PCW-1:0] mPc;
    logic [1:0]     mSkip;

    function automatic int hwLen(input logic [15:0] h);
        if (h[15:12] != 4'hF) return 1;
        if (h[11:10] == 2'b11) return 3;
        return 2;
    endfunction

    function automatic int mHeadLen();
        return (mq.size() == 0) ? 1 : hwLen(mq[0]);
    endfunction

    function automatic bit mValid();
        return (mq.size() >= 1) && (mq.size() >= mHeadLen());
    endfunction

    function automatic logic [63:0] mWord();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < mq.size() && i < mHeadLen()) w[16*i +: 16] = mq[i];
        end
        return w;
    endfunction

    function automatic bit mReady();
        return ((mq.size() + 4 - int'(mSkip)) <= 8) && !redirect && !reset;
    endfunction

    task automatic resetModel();
        mq.delete();
        mPc   = '0;
        mSkip = '0;
    endtask

    task automatic drive(input logic fv, input logic [63:0] fd, input logic rd,
                         input logic [PCW-1:0] rpc, input logic tk);
        fetchValid = fv;
        fetchData  = fd;
        redirect   = rd;
        redirectPc = rpc;
        istrTake   = tk;
        #1;
    endtask

    task automatic checkModel(input string tag);
        check({tag, ".valid"}, 64'(istrValid), 64'(mValid()));
        check({tag, ".ready"}, 64'(fetchReady), 64'(mReady()));
        check({tag, ".word"},  istrWord, mWord());
        check({tag, ".pc"},    64'(istrPc), 64'(mPc));
        if (mValid()) check({tag, ".len"}, 64'(istrLen), 64'(mHeadLen() - 1));
    endtask

    // Update the model from the inputs of this cycle, then cross the clock edge.
    task automatic advance(output bit accepted);
        int n;
        bit v;
        bit rdy;
        n   = mHeadLen();
        v   = mValid();
        rdy = mReady();
        accepted = fetchValid && rdy;
        if (redirect) begin
            mq.delete();
            mPc   = {redirectPc[PCW-1:1], 1'b0};
            mSkip = redirectPc[2:1];
        end else begin
            if (istrTake && v) begin
                for (int k = 0; k < n; k++) void'(mq.pop_front());
                mPc = mPc + PCW'(2 * n);
            end
            if (accepted) begin
                for (int i = int'(mSkip); i < 4; i++) mq.push_back(fetchData[16*i +: 16]);
                mSkip = '0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic fv, input logic [63:0] fd,
                        input logic rd, input logic [PCW-1:0] rpc, input logic tk);
        bit acc;
        drive(fv, fd, rd, rpc, tk);
        checkModel(tag);
        advance(acc);
    endtask

    typedef struct packed {
        logic        fv;
        logic [63:0] data;
        logic        rd;
        logic [31:0] rpc;
        logic        tk;
        logic        expValid;
        logic [1:0]  expLen;
        logic [63:0] expWord;
        logic [31:0] expPc;
        logic        expReady;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  len;
        logic [63:0] word;
    } instr_t;

    vec_t        vecs [21];
    logic [15:0] mem [MEMHW];
    instr_t      prog [$];

    initial begin
        bit          acc;
        int          p;
        int          k;
        int          idx;
        int          cyc;
        int          fa;
        logic        fv;
        logic        tk;
        logic [63:0] fd;
        logic [63:0] w;
        logic [15:0] h;
        logic [31:0] base;

        //            fv  data                    rd  rpc     tk   val len word                     pc      rdy
        vecs[0]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 64'h0,                 32'h0,   1'b1};
        vecs[1]  = '{1'b1, 64'h0000_F200_3000_1000, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,                 32'h0,   1'b1};
        vecs[2]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h1000,              32'h0,   1'b1};
        vecs[3]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h3000,              32'h2,   1'b1};
        vecs[4]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd1, 64'h0000_F200,         32'h4,   1'b1};
        vecs[5]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 64'h0,                 32'h8,   1'b1};
        vecs[6]  = '{1'b1, 64'hFC00_0003_0002_0001, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,                 32'h8,   1'b1};
        vecs[7]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h1,                 32'h8,   1'b1};
        vecs[8]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h2,                 32'hA,   1'b1};
        vecs[9]  = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h3,                 32'hC,   1'b1};
        vecs[10] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 64'hFC00,              32'hE,   1'b1};
        vecs[11] = '{1'b1, 64'h4444_3333_2222_1111, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 64'hFC00,              32'hE,   1'b1};
        vecs[12] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd2, 64'h0000_2222_1111_FC00, 32'hE, 1'b0};
        vecs[13] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h3333,              32'h14,  1'b1};
        vecs[14] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h4444,              32'h16,  1'b1};
        vecs[15] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 64'h0,                 32'h18,  1'b1};
        vecs[16] = '{1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 32'h104, 1'b0, 1'b0, 2'd0, 64'h0,               32'h18,  1'b0};
        vecs[17] = '{1'b1, 64'h0004_0003_0002_0001, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,                 32'h104, 1'b1};
        vecs[18] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h3,                 32'h104, 1'b1};
        vecs[19] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b1, 1'b1, 2'd0, 64'h4,                 32'h106, 1'b1};
        vecs[20] = '{1'b0, 64'h0,                 1'b0, 32'h0,   1'b0, 1'b0, 2'd0, 64'h0,                 32'h108, 1'b1};

        reset      = 1'b1;
        fetchValid = 1'b0;
        fetchData  = '0;
        redirect   = 1'b0;
        redirectPc = '0;
        istrTake   = 1'b0;
        resetModel();
        repeat (2) @(posedge clock);
        #1;
        check("rst.valid", 64'(istrValid), 64'd0);
        check("rst.word",  istrWord, 64'd0);
        check("rst.len",   64'(istrLen), 64'd0);
        check("rst.ready", 64'(fetchReady), 64'd0);
        check("rst.pc",    64'(istrPc), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].fv, vecs[i].data, vecs[i].rd, vecs[i].rpc, vecs[i].tk);
            check($sformatf("vec%0d.valid", i), 64'(istrValid),  64'(vecs[i].expValid));
            check($sformatf("vec%0d.word", i),  istrWord,        vecs[i].expWord);
            check($sformatf("vec%0d.pc", i),    64'(istrPc),     64'(vecs[i].expPc));
            check($sformatf("vec%0d.ready", i), 64'(fetchReady), 64'(vecs[i].expReady));
            if (vecs[i].expValid) check($sformatf("vec%0d.len", i), 64'(istrLen), 64'(vecs[i].expLen));
            advance(acc);
        end

        // Fill to eight halfwords, then drain and check backpressure.
        step("fill0", 1'b1, 64'h0004_0003_0002_0001, 1'b0, '0, 1'b0);
        step("fill1", 1'b1, 64'h0008_0007_0006_0005, 1'b0, '0, 1'b0);
        drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, '0, 1'b0);
        check("full8.ready", 64'(fetchReady), 64'd0);
        checkModel("full8");
        advance(acc);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("full8.word", istrWord, 64'h1);
        check("full8t.ready", 64'(fetchReady), 64'd0);
        advance(acc);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("full7.ready", 64'(fetchReady), 64'd0);
        checkModel("full7");
        advance(acc);
        for (int i = 0; i < 3; i++) step("drain", 1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("drain4.ready", 64'(fetchReady), 64'd1);
        advance(acc);
        step("takeacc", 1'b1, 64'h000C_000B_000A_0009, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        check("takeacc.word", istrWord, 64'h6);
        check("takeacc.ready", 64'(fetchReady), 64'd0);
        advance(acc);
        for (int i = 0; i < 2; i++) step("pre_rst", 1'b0, '0, 1'b0, '0, 1'b1);

        // Asynchronous reset mid-cycle with five halfwords buffered.
        fetchValid = 1'b0;
        istrTake   = 1'b0;
        reset      = 1'b1;
        #2;
        check("arst.valid", 64'(istrValid), 64'd0);
        check("arst.word",  istrWord, 64'd0);
        check("arst.ready", 64'(fetchReady), 64'd0);
        check("arst.pc",    64'(istrPc), 64'd0);
        check("arst.len",   64'(istrLen), 64'd0);
        resetModel();
        @(posedge clock);
        #1;
        reset = 1'b0;
        step("post_rst", 1'b0, '0, 1'b0, '0, 1'b0);

        // Random instruction streams at each starting halfword offset.
        for (int run = 0; run < 4; run++) begin
            base = 32'h1000 * (run + 1);
            prog.delete();
            for (int i = 0; i < MEMHW; i++) mem[i] = '0;
            p = run;
            while (1) begin
                k = $urandom_range(1, 3);
                if (p + k > MEMHW) break;
                case (k)
                    1:       h = {4'($urandom_range(0, 14)), 12'($urandom)};
                    2:       h = {4'hF, 2'($urandom_range(0, 2)), 10'($urandom)};
                    default: h = {4'hF, 2'b11, 10'($urandom)};
                endcase
                w = '0;
                w[15:0] = h;
                mem[p] = h;
                for (int j = 1; j < k; j++) begin
                    h = 16'($urandom);
                    mem[p + j] = h;
                    w[16*j +: 16] = h;
                end
                prog.push_back('{base + 32'(2 * p), 2'(k - 1), w});
                p += k;
            end

            step("rnd_redir", 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, base + 32'(2 * run), 1'b0);
            fa  = 0;
            idx = 0;
            cyc = 0;
            while (idx < prog.size() && cyc < 4000) begin
                fv = (fa < MEMHW) && ($urandom_range(0, 9) < 7);
                fd = (fa < MEMHW) ? {mem[fa+3], mem[fa+2], mem[fa+1], mem[fa]} : 64'h0;
                tk = ($urandom_range(0, 9) < 6);
                drive(fv, fd, 1'b0, '0, tk);
                checkModel("rnd");
                if (tk && mValid()) begin
                    check("rnd.istr_pc",   64'(istrPc),  64'(prog[idx].pc));
                    check("rnd.istr_word", istrWord,     prog[idx].word);
                    check("rnd.istr_len",  64'(istrLen), 64'(prog[idx].len));
                    idx++;
                end
                advance(acc);
                if (acc) fa += 4;
                cyc++;
            end
            check($sformatf("rnd%0d.done", run), 64'(idx), 64'(prog.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
